adc_dac_sequencer: RTL and testbench

ADC_DAC_SEQUENCER -- requirements
Module: adc_dac_sequencer

---
 rtl/adc_dac_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_adc_dac_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_dac_sequencer.sv
// rtl/adc_dac_sequencer.sv - sample sequencer: ADC read, optional gain, DAC write
//
// Purpose: on each accepted sample tick, start the ADC reader, wait for its
// result, process it, then start the DAC writer and wait for it to finish.
// Ticks arriving mid-transfer are dropped and counted; stuck waits are aborted
// after TIMEOUT_CYCLES cycles and counted.
//
// Optional feature macro: ADC_DAC_SEQ_GAIN_EN adds gain_i (unsigned Q8.8) and
// scales the sample by it with saturation; without it the sample passes through.
//
// Ports:
//   clk_i          rising-edge system clock
//   reset_i        synchronous active-high reset
//   enable_i       accept sample ticks when high
//   sample_tick_i  single-cycle sample request
//   adc_start_o    single-cycle ADC reader start
//   adc_idle_i     ADC reader idle flag
//   adc_data_i     signed ADC result, valid while adc_idle_i is high
//   dac_start_o    single-cycle DAC writer start
//   dac_idle_i     DAC writer idle flag
//   dac_data_o     signed DAC word
//   busy_o         high whenever a transfer is in progress
//   overrun_cnt_o  saturating count of dropped ticks
//   timeout_cnt_o  saturating count of aborted transfers
//   gain_i         unsigned Q8.8 gain (ADC_DAC_SEQ_GAIN_EN builds only)

module adc_dac_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             sample_tick_i,
  output logic             adc_start_o,
  input  logic             adc_idle_i,
  input  logic [15:0]      adc_data_i,
  output logic             dac_start_o,
  input  logic             dac_idle_i,
  output logic [15:0]      dac_data_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] overrun_cnt_o,
  output logic [CNT_W-1:0] timeout_cnt_o
`ifdef ADC_DAC_SEQ_GAIN_EN
  ,
  input  logic [15:0]      gain_i
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    ADC_START,
    ADC_WAIT,
    PROC,
    DAC_START,
    DAC_WAIT
  } state_t;

  // Last wait cycle index: a wait may occupy at most TIMEOUT_CYCLES cycles.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t             state;
  state_t             state_next;
  logic [15:0]        wait_cnt;
  logic [15:0]        sample;
  logic [15:0]        processed;
  logic [15:0]        dac_data;
  logic [CNT_W-1:0]   overrun_cnt;
  logic [CNT_W-1:0]   timeout_cnt;
  logic               adc_start;
  logic               dac_start;
  logic               capture;
  logic               load_dac;
  logic               timeout_hit;
  logic               wait_last;
  logic               wait_first;

  assign wait_last  = (wait_cnt == WAIT_LAST);
  // The peripheral's idle flag only drops a cycle after its start pulse, so
  // the first wait cycle would see a stale "idle" and must be ignored.
  assign wait_first = (wait_cnt == 16'd0);

`ifdef ADC_DAC_SEQ_GAIN_EN
  logic signed [32:0] product;
  logic signed [32:0] scaled;

  assign product = $signed(sample) * $signed({1'b0, gain_i});
  assign scaled  = product >>> 8;

  always_comb begin
    processed = scaled[15:0];
    if (scaled > 33'sd32767) begin
      processed = 16'h7FFF;
    end else if (scaled < -33'sd32768) begin
      processed = 16'h8000;
    end
  end
`else
  assign processed = sample;
`endif

  always_comb begin
    state_next  = state;
    adc_start   = 1'b0;
    dac_start   = 1'b0;
    capture     = 1'b0;
    load_dac    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (sample_tick_i && enable_i) begin
          state_next = ADC_START;
        end
      end
      ADC_START: begin
        adc_start  = 1'b1;
        state_next = ADC_WAIT;
      end
      ADC_WAIT: begin
        // Completion wins over a timeout landing on the same cycle.
        if (!wait_first && adc_idle_i) begin
          capture    = 1'b1;
          state_next = PROC;
        end else if (wait_last) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      PROC: begin
        load_dac   = 1'b1;
        state_next = DAC_START;
      end
      DAC_START: begin
        dac_start  = 1'b1;
        state_next = DAC_WAIT;
      end
      DAC_WAIT: begin
        if (!wait_first && dac_idle_i) begin
          state_next = IDLE;
        end else if (wait_last) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      wait_cnt    <= 16'd0;
      sample      <= 16'd0;
      dac_data    <= 16'd0;
      overrun_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      state <= state_next;
      // Every wait state is entered from a different state, so clearing on
      // any state change gives a fresh count on each wait entry.
      if (state_next != state) begin
        wait_cnt <= 16'd0;
      end else if (state == ADC_WAIT || state == DAC_WAIT) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (capture) begin
        sample <= adc_data_i;
      end
      if (load_dac) begin
        dac_data <= processed;
      end
      // Any enabled tick outside IDLE is dropped, including one on the cycle
      // the transfer finishes.
      if (sample_tick_i && enable_i && state != IDLE && overrun_cnt != '1) begin
        overrun_cnt <= overrun_cnt + 1'b1;
      end
      if (timeout_hit && timeout_cnt != '1) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end
    end
  end

  // Strobes are masked while reset is asserted so they read 0 even on the
  // cycle before the reset edge takes effect.
  assign adc_start_o   = adc_start && !reset_i;
  assign dac_start_o   = dac_start && !reset_i;
  assign busy_o        = (state != IDLE) && !reset_i;
  assign dac_data_o    = dac_data;
  assign overrun_cnt_o = overrun_cnt;
  assign timeout_cnt_o = timeout_cnt;

endmodule

// File: tb/tb_adc_dac_sequencer.sv
// tb/tb_adc_dac_sequencer.sv - self-checking bench for adc_dac_sequencer

module tb_adc_dac_sequencer;

  localparam int TO = 24;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          tick;
  logic          adc_start;
  logic          adc_idle;
  logic [15:0]   adc_data;
  logic          dac_start;
  logic          dac_idle;
  logic [15:0]   dac_data;
  logic          busy;
  logic [CW-1:0] overrun_cnt;
  logic [CW-1:0] timeout_cnt;
  logic [15:0]   gain;

  int checks = 0;
  int errors = 0;

  int          m_ovr;
  int          m_tmo;
  logic [15:0] m_dac;

  always #5 clk = ~clk;

  adc_dac_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .enable_i      (enable),
    .sample_tick_i (tick),
    .adc_start_o   (adc_start),
    .adc_idle_i    (adc_idle),
    .adc_data_i    (adc_data),
    .dac_start_o   (dac_start),
    .dac_idle_i    (dac_idle),
    .dac_data_o    (dac_data),
    .busy_o        (busy),
    .overrun_cnt_o (overrun_cnt),
    .timeout_cnt_o (timeout_cnt)
`ifdef ADC_DAC_SEQ_GAIN_EN
    ,
    .gain_i        (gain)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected DAC word for a captured ADC sample, from plain integer arithmetic.
  function automatic logic [15:0] expect_dac(input logic [15:0] a);
`ifdef ADC_DAC_SEQ_GAIN_EN
    longint p;
    p = longint'($signed(a)) * longint'(gain);
    p = p >>> 8;
    if (p > 32767) return 16'h7FFF;
    if (p < -32768) return 16'h8000;
    return p[15:0];
`else
    return a;
`endif
  endfunction

  // One transfer started by a tick at cycle 0.
  //   k: ADC wait cycle on which the reader reports idle (0 = stuck low)
  //   j: DAC wait cycle on which the writer reports idle (0 = stuck low)
  // Timeline: adc_start at 1, ADC wait from 2, idle seen at 1+k, dac_start at
  // k+3, DAC wait from k+4, idle seen at k+3+j, IDLE one cycle later. A wait
  // longer than TO cycles is aborted after its TO-th cycle.
  task automatic transfer(input int k, input int j, input logic [15:0] val,
                          input int tick_pct, input int reset_at);
    bit adc_to, dac_to, t, e;
    int d0, end_c;
    adc_to = (k == 0) || (k > TO);
    dac_to = (j == 0) || (j > TO);
    d0 = adc_to ? (1 << 20) : k + 3;
    if (adc_to)      end_c = TO + 2;
    else if (dac_to) end_c = d0 + TO + 1;
    else             end_c = d0 + j + 1;
    for (int c = 0; c <= end_c; c++) begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(c >= 1 && c < end_c));
      check("adc_start", 32'(adc_start), 32'(c == 1));
      check("dac_start", 32'(dac_start), 32'(c == d0));
      if (c == 0 || c == d0 || c == end_c) begin
        check("dac_data", 32'(dac_data), 32'(m_dac));
        check("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
        check("timeout_cnt", 32'(timeout_cnt), 32'(m_tmo));
      end
      if (c == reset_at) begin
        reset = 1'b1;
        tick  = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_adc_start", 32'(adc_start), 32'd0);
        check("rst_dac_start", 32'(dac_start), 32'd0);
        m_ovr = 0;
        m_tmo = 0;
        m_dac = 16'd0;
        return;
      end
      reset = 1'b0;
      if (c == 0) begin
        t = 1'b1;
        e = 1'b1;
      end else if (c == end_c) begin
        t = 1'b0;
        e = 1'($urandom);
      end else begin
        t = ($urandom % 100) < tick_pct;
        e = (tick_pct >= 100) ? 1'b1 : 1'($urandom);
      end
      tick   = t;
      enable = e;
      if (t && e && c >= 1 && c < end_c && m_ovr < 255) m_ovr++;
      if (c == end_c - 1 && (adc_to || dac_to) && m_tmo < 255) m_tmo++;
      if (c == d0 - 1) m_dac = expect_dac(val);
      adc_idle = (k == 0) ? (c == 0) : (c <= 2 || c >= 1 + k);
      adc_data = (k != 0 && c >= 1 + k) ? val : 16'($urandom);
      dac_idle = (c <= d0 + 1) || (j != 0 && c >= d0 + j);
    end
  endtask

  // Ticks with enable low: must neither start a transfer nor be counted.
  task automatic disabled_ticks(input int n);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      check("dis_busy", 32'(busy), 32'd0);
      check("dis_adc_start", 32'(adc_start), 32'd0);
      check("dis_overrun", 32'(overrun_cnt), 32'(m_ovr));
      tick   = (i < n);
      enable = 1'b0;
    end
    tick = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    tick     = 1'b0;
    adc_idle = 1'b1;
    dac_idle = 1'b1;
    adc_data = 16'd0;
    gain     = 16'h0100;
    m_ovr    = 0;
    m_tmo    = 0;
    m_dac    = 16'd0;

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_adc_start", 32'(adc_start), 32'd0);
    check("reset_dac_start", 32'(dac_start), 32'd0);
    check("reset_overrun", 32'(overrun_cnt), 32'd0);
    check("reset_timeout", 32'(timeout_cnt), 32'd0);
    check("reset_dac_data", 32'(dac_data), 32'd0);

    // Nominal transfer; tick lands on the first cycle out of reset.
    transfer(18, 3, 16'h1234, 0, -1);
    check("nominal_data", 32'(dac_data), 32'h1234);

    disabled_ticks(5);
    check("disabled_overrun", 32'(overrun_cnt), 32'd0);

    // ADC stuck busy: abort, count, DAC word unchanged.
    transfer(0, 3, 16'h5555, 0, -1);
    check("adc_timeout_once", 32'(timeout_cnt), 32'd1);
    check("adc_timeout_keep", 32'(dac_data), 32'h1234);

    // DAC stuck busy after a valid sample.
    transfer(4, 0, 16'hBEEF, 50, -1);

    // Reset in the middle of DAC_WAIT, then a fresh transfer straight after.
    transfer(5, 4, 16'h0F0F, 50, 10);
    transfer(6, 3, 16'h7123, 30, -1);

`ifdef ADC_DAC_SEQ_GAIN_EN
    gain = 16'h0200;
    transfer(3, 2, 16'h5000, 0, -1);
    check("gain_sat_pos", 32'(dac_data), 32'h7FFF);
    transfer(3, 2, 16'hA000, 0, -1);
    check("gain_sat_neg", 32'(dac_data), 32'h8000);
    gain = 16'h0080;
    transfer(3, 2, 16'h0100, 0, -1);
    check("gain_half", 32'(dac_data), 32'h0080);
`endif

    for (int i = 0; i < 50; i++) begin
`ifdef ADC_DAC_SEQ_GAIN_EN
      gain = 16'($urandom);
`endif
      transfer($urandom_range(2, TO + 2), $urandom_range(2, TO + 2),
               16'($urandom), 60, -1);
    end

    // Drive the overrun counter into saturation.
    for (int i = 0; i < 20 && m_ovr < 255; i++) begin
      transfer(TO - 2, TO - 2, 16'($urandom), 100, -1);
    end
    transfer(5, 3, 16'($urandom), 100, -1);
    check("overrun_saturated", 32'(overrun_cnt), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
